// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for pipe_stage_skid: occupancy state encodings and the
// bubble constants parents use when assembling NOP_VAL.
package pipe_stage_skid_pkg;

  typedef enum logic [1:0] {
    PSS_EMPTY = 2'd0,
    PSS_ONE   = 2'd1,
    PSS_FULL  = 2'd2
  } pss_state_e;

  // Bubble building blocks: a no-op result-op code and an all-zero instruction.
  localparam logic [3:0]  PSS_RESOP_NOP = 4'd0;
  localparam logic [31:0] PSS_INSTR_NOP = 32'h0000_0000;

  function automatic logic [1:0] pss_level(input pss_state_e s);
    return logic'(s == PSS_FULL) ? 2'd2 : (s == PSS_ONE) ? 2'd1 : 2'd0;
  endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating event counter; cleared only by the asynchronous reset.
module pipe_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage register with a one-entry skid buffer and flush.
// Define PIPE_STAGE_STATS_EN to add saturating stall/flush counters.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int                DATA_W  = 128,
  parameter logic [DATA_W-1:0] NOP_VAL = {DATA_W{1'b0}},
  parameter int                CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic [DATA_W-1:0] up_data_i,
  output logic              dn_valid_o,
  input  logic              dn_ready_i,
  output logic [DATA_W-1:0] dn_data_o,
  output logic [1:0]        level_o
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

  pss_state_e        state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              up_xfer;

  // Ready depends only on registered state, so no downstream->upstream comb path.
  assign up_ready_o = (state_q != PSS_FULL);
  assign dn_valid_o = (state_q != PSS_EMPTY);
  assign dn_data_o  = main_q;
  assign level_o    = pss_level(state_q);
  assign up_xfer    = up_valid_i & up_ready_o;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = PSS_EMPTY;
      main_d  = NOP_VAL;
      skid_d  = NOP_VAL;
    end else begin
      unique case (state_q)
        PSS_EMPTY: begin
          if (up_xfer) begin
            main_d  = up_data_i;
            state_d = PSS_ONE;
          end
        end
        PSS_ONE: begin
          if (up_xfer && dn_ready_i) begin
            main_d = up_data_i;
          end else if (up_xfer) begin
            // Downstream stalled: park the new beat behind the head.
            skid_d  = up_data_i;
            state_d = PSS_FULL;
          end else if (dn_ready_i) begin
            main_d  = NOP_VAL;
            state_d = PSS_EMPTY;
          end
        end
        PSS_FULL: begin
          if (dn_ready_i) begin
            main_d  = skid_q;
            skid_d  = NOP_VAL;
            state_d = PSS_ONE;
          end
        end
        default: begin
          state_d = PSS_EMPTY;
          main_d  = NOP_VAL;
          skid_d  = NOP_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PSS_EMPTY;
      main_q  <= NOP_VAL;
      skid_q  <= NOP_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (dn_valid_o & ~dn_ready_i),
    .cnt_o (stall_cnt_o)
  );

  pipe_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (flush_i),
    .cnt_o (flush_cnt_o)
  );
`endif

endmodule
